xrv_if_pfq: RTL
===============

// Module: xrv_if_pfq
// PURPOSE
//   Parametrised instruction fetcher with prefetch queue for the xriscv core. Issues word
//   fetches over a req/gnt/rvalid bus with up to MAX_OUTST requests in flight and buffers
//   returned data in a halfword-granular queue. Realigns 16/32-bit instructions, including
//   32-bit ones that span a word boundary, and hands raw instructions to decode on a
//   valid/ready handshake. Decompression stays downstream (xrv_i_decompress).
// PARAMETERS
//   QDEPTH     4      queue capacity in 32-bit words (>=2, power of 2); holds 2*QDEPTH halfwords
//   MAX_OUTST  2      max granted-but-not-returned fetches (1..QDEPTH)
//   RESET_PC   32'h0  fetch/PC start address after reset (bit0 = 0)
// PORTS
//   clk                 in   1   core clock
//   rstb                in   1   async active-low reset
//   jmp                 in   1   redirect: flush queue, restart fetch at jmp_addr
//   jmp_addr            in   32  redirect target, halfword aligned (bit0 ignored)
//   i_req               out  1   fetch request
//   i_addr              out  32  fetch word address, bits[1:0] always 0
//   i_gnt               in   1   request accepted this cycle (valid only with i_req)
//   i_rvalid            in   1   read data returned, in grant order
//   i_rdata             in   32  read data
//   inst_valid          out  1   inst/inst_pc/inst_is_compressed valid
//   inst_ready          in   1   decode accepts instruction
//   inst                out  32  raw instruction; compressed -> {16'h0, hw}
//   inst_pc             out  32  PC of inst
//   inst_is_compressed  out  1   inst[1:0] != 2'b11
// BEHAVIOUR
//   Reset: i_req=0, inst_valid=0, fetch_addr=inst_pc=RESET_PC, queue empty, outst=0,
//     discard=0. i_req also held 0 for the first cycle after rstb rises (start flop).
//   Issue: i_req = started & ~jmp & (outst<MAX_OUTST) & (hw_cnt + 2*outst + 2 <= 2*QDEPTH).
//     i_addr = {fetch_addr[31:2],2'b00}; held stable while i_req & ~i_gnt.
//     i_req&i_gnt: fetch_addr += 4, outst += 1. i_rvalid: outst -= 1. Both in one cycle: net 0.
//   Fill: i_rvalid & discard==0 writes {rdata[31:16], rdata[15:0]} as 2 halfwords (low first),
//     except the first response after a jmp with jmp_addr[1]=1: only rdata[31:16] written.
//     The credit rule guarantees the queue never overflows; overflow is an assertion failure.
//   Redirect (jmp=1): queue cleared, inst_valid forced 0 (no handshake that cycle),
//     fetch_addr<={jmp_addr[31:2],2'b00}, inst_pc<={jmp_addr[31:1],1'b0}, skip_hi<=jmp_addr[1],
//     discard <= outst - i_rvalid (in-flight responses to drop). No grant can occur (i_req=0).
//     Each later i_rvalid with discard>0 decrements discard, data dropped, outst still decrements.
//     Back-to-back jmp: discard recomputed from current outst; last jmp wins.
//   Output: head halfword h0, next h1.
//     h0[1:0]!=2'b11: inst_valid = hw_cnt>=1, inst={16'h0,h0}, compressed=1.
//     else: inst_valid = hw_cnt>=2, inst={h1,h0}, compressed=0 (spanning words handled natively).
//     inst_valid & inst_ready & ~jmp: pop 1 or 2 halfwords, inst_pc += 2 or 4 (mod 2^32).
//     inst/inst_pc/inst_is_compressed stable while inst_valid & ~inst_ready & ~jmp.
//     Pop and fill in the same cycle both apply; hw_cnt updated as +fill-pop.
//   Latency: gnt->rvalid of N cycles gives inst_valid the cycle after rvalid (registered queue).
//   Wrap-around: fetch_addr and inst_pc wrap at 2^32; queue pointers wrap modulo 2*QDEPTH.
//   Reset mid-operation: all state returns to reset values immediately; in-flight bus responses
//     after reset are not tracked (bus is reset together with the core).
// TESTING
//   1 Reset release, memory 1-cycle gnt/rvalid, RESET_PC=0: i_addr 0,4,8..; inst_pc 0,4,8 for
//     32-bit ops; i_req low in first cycle after rstb rises.
//   2 Word 0x0001_4501 (two c.addi/c.li): two compressed insts, inst=0x4501 then 0x0001,
//     inst_pc 0 then 2; next 32-bit inst at pc 4.
//   3 Words {0x0513,0x4501} then {0x????,0x0000}: c.li at pc 0, 32-bit 0x00000513 at pc 2
//     spanning words, compressed=0.
//   4 Two fetches in flight (gnt without rvalid), jmp to 0x102: both responses dropped,
//     next i_addr 0x100, first inst from rdata[31:16] with inst_pc 0x102.
//   5 inst_ready=0 with QDEPTH=4: i_req drops once 4 words queued/in flight; outputs stable;
//     ready high -> fetching resumes, no data lost or duplicated.
//   6 i_gnt delayed 3 cycles: i_req/i_addr held stable; jmp during wait withdraws request,
//     new address issued next cycle.

Source files
------------

// File: rtl/xrv_if_pfq_if.sv
// Fetch-side bus bundle for xrv_if_pfq.
//   Instruction memory bus: i_req/i_addr out, i_gnt/i_rvalid/i_rdata in.
//   Decode handshake: inst_valid/inst/inst_pc/inst_is_compressed out, inst_ready in.
// master = fetcher, slave = memory/decode side.
interface xrv_if_pfq_if;
  logic        i_req;
  logic [31:0] i_addr;
  logic        i_gnt;
  logic        i_rvalid;
  logic [31:0] i_rdata;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        inst_is_compressed;

  modport master (
    output i_req, i_addr,
    input  i_gnt, i_rvalid, i_rdata,
    output inst_valid, inst, inst_pc, inst_is_compressed,
    input  inst_ready
  );

  modport slave (
    input  i_req, i_addr,
    output i_gnt, i_rvalid, i_rdata,
    input  inst_valid, inst, inst_pc, inst_is_compressed,
    output inst_ready
  );
endinterface

// File: rtl/xrv_if_pfq.sv
// Instruction fetcher with halfword-granular prefetch queue for the xriscv core.
// Issues word fetches (up to MAX_OUTST in flight), buffers returned halfwords,
// realigns 16/32-bit instructions (including word-spanning ones) and presents
// raw instructions to decode on a valid/ready handshake.
// Ports:
//   clk       core clock
//   rstb      asynchronous active-low reset
//   jmp       redirect: flush queue, restart fetch at jmp_addr
//   jmp_addr  redirect target (bit0 ignored)
//   bus       xrv_if_pfq_if.master: fetch bus and decode handshake
module xrv_if_pfq #(
  parameter int unsigned QDEPTH    = 4,
  parameter int unsigned MAX_OUTST = 2,
  parameter logic [31:0] RESET_PC  = 32'h0
) (
  input  logic                clk,
  input  logic                rstb,
  input  logic                jmp,
  input  logic [31:0]         jmp_addr,
  xrv_if_pfq_if.master        bus
);
  localparam int unsigned HW = 2 * QDEPTH;
  localparam int unsigned PW = $clog2(HW);
  localparam int unsigned CW = $clog2(HW + 1);
  localparam int unsigned OW = $clog2(MAX_OUTST + 1);

  logic          r_started;
  logic [31:0]   r_fetch_addr;
  logic [31:0]   r_pc;
  logic [OW-1:0] r_outst;
  logic [OW-1:0] r_discard;
  logic          r_skip_hi;
  logic [15:0]   r_q [HW];
  logic [PW-1:0] r_rd;
  logic [PW-1:0] r_wr;
  logic [CW-1:0] r_cnt;

  logic [15:0]   w_h0;
  logic [15:0]   w_h1;
  logic          w_comp;
  logic          w_valid;
  logic          w_pop;
  logic [1:0]    w_pop_n;
  logic          w_ret;
  logic          w_fill;
  logic [1:0]    w_fill_n;
  logic [31:0]   w_credit;
  logic          w_req;
  logic          w_grant;
  logic [CW:0]   w_cnt_next;
  logic          w_unused_jmp_lsb;

  assign w_unused_jmp_lsb = jmp_addr[0];

  always_comb begin
    w_h0    = r_q[r_rd];
    w_h1    = r_q[r_rd + PW'(1)];
    w_comp  = (w_h0[1:0] != 2'b11);
    w_valid = (w_comp ? (r_cnt >= CW'(1)) : (r_cnt >= CW'(2))) & ~jmp;
    w_pop   = w_valid & bus.inst_ready;
    w_pop_n = w_comp ? 2'd1 : 2'd2;

    // Responses arriving with nothing tracked (e.g. straight after reset) are ignored.
    w_ret    = bus.i_rvalid & (r_outst != '0);
    w_fill   = w_ret & ~jmp & (r_discard == '0);
    w_fill_n = r_skip_hi ? 2'd1 : 2'd2;

    // Reserve queue space for every in-flight word plus the one about to be requested.
    w_credit = 32'(r_cnt) + 32'(r_outst) * 32'd2 + 32'd2;
    w_req    = r_started & ~jmp & (32'(r_outst) < MAX_OUTST) & (w_credit <= HW);
    w_grant  = w_req & bus.i_gnt;

    w_cnt_next = {1'b0, r_cnt};
    if (w_fill) w_cnt_next = w_cnt_next + (CW+1)'(w_fill_n);
    if (w_pop)  w_cnt_next = w_cnt_next - (CW+1)'(w_pop_n);
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      r_started    <= 1'b0;
      r_fetch_addr <= {RESET_PC[31:2], 2'b00};
      r_pc         <= {RESET_PC[31:1], 1'b0};
      r_outst      <= '0;
      r_discard    <= '0;
      r_skip_hi    <= 1'b0;
      r_rd         <= '0;
      r_wr         <= '0;
      r_cnt        <= '0;
      for (int unsigned k = 0; k < HW; k++) r_q[k] <= '0;
    end else begin
      r_started <= 1'b1;
      r_outst   <= r_outst + OW'(w_grant) - OW'(w_ret);
      if (jmp) begin
        r_fetch_addr <= {jmp_addr[31:2], 2'b00};
        r_pc         <= {jmp_addr[31:1], 1'b0};
        r_skip_hi    <= jmp_addr[1];
        r_rd         <= '0;
        r_wr         <= '0;
        r_cnt        <= '0;
        // A response landing in the redirect cycle is already dropped with the flush.
        r_discard    <= r_outst - OW'(w_ret);
      end else begin
        if (w_grant) r_fetch_addr <= r_fetch_addr + 32'd4;
        if (w_pop) begin
          r_pc <= r_pc + (w_comp ? 32'd2 : 32'd4);
          r_rd <= r_rd + PW'(w_pop_n);
        end
        if (w_fill) begin
          if (r_skip_hi) begin
            r_q[r_wr] <= bus.i_rdata[31:16];
          end else begin
            r_q[r_wr]          <= bus.i_rdata[15:0];
            r_q[r_wr + PW'(1)] <= bus.i_rdata[31:16];
          end
          r_wr      <= r_wr + PW'(w_fill_n);
          r_skip_hi <= 1'b0;
        end else if (w_ret && (r_discard != '0)) begin
          r_discard <= r_discard - OW'(1);
        end
        r_cnt <= w_cnt_next[CW-1:0];
      end
    end
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (!rstb) (32'(w_cnt_next) <= HW));

  assign bus.i_req              = w_req;
  assign bus.i_addr             = r_fetch_addr;
  assign bus.inst_valid         = w_valid;
  assign bus.inst               = w_comp ? {16'h0, w_h0} : {w_h1, w_h0};
  assign bus.inst_pc            = r_pc;
  assign bus.inst_is_compressed = w_comp;
endmodule
